// File: rtl/sdram_write_burst_ctrl.sv
// Full-page SDRAM write burst sequencer; ACTIVE is issued one cycle after accept, upstream is paced by o_wr_ack.
// Optional row-boundary split is selected by SDRAM_WR_ROW_CROSS_EN; otherwise the column wraps inside the open row.
module sdram_write_burst_ctrl #(
   parameter int DQ_W  = 16,
   parameter int ROW_W = 13,
   parameter int COL_W = 9,
   parameter int BA_W  = 2,
   parameter int LEN_W = 10,
   parameter int T_RCD = 2,
   parameter int T_WR  = 2,
   parameter int T_RP  = 2
) (
   input  logic                        i_sysclk,
   input  logic                        i_sysrst,
   input  logic                        i_init_done,
   input  logic                        i_write_start,
   input  logic [BA_W+ROW_W+COL_W-1:0] i_wr_addr,
   input  logic [LEN_W-1:0]            i_wr_burst_len,
   input  logic [DQ_W-1:0]             i_wr_data,
   output logic [3:0]                  o_wr_cmd,
   output logic [BA_W-1:0]             o_wr_ba,
   output logic [ROW_W-1:0]            o_wr_addr,
   output logic [DQ_W-1:0]             o_wr_data,
   output logic                        o_wr_dq_oe,
   output logic                        o_wr_ack,
   output logic                        o_wr_done,
   output logic                        o_busy
);
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_BSTOP = 4'b0110;
   localparam logic [3:0] CMD_PRE   = 4'b0010;
   localparam int WAIT_W = 8;
   localparam logic [ROW_W-1:0] ADDR_A10 = ROW_W'(1) << 10;

   typedef enum logic [3:0] {
      S_IDLE, S_ACT, S_TRCD, S_WRITE, S_BSTOP, S_TWR, S_PRE, S_TRP, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [BA_W-1:0]     bank_q, bank_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                cross_q, cross_d;
   logic                hold_q, hold_d;
   logic [3:0]          cmd_q, cmd_d;
   logic [BA_W-1:0]     ba_q, ba_d;
   logic [ROW_W-1:0]    addr_q, addr_d;
   logic                oe_q, oe_d;
   logic                ack_q, ack_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic                accept;
   logic                trp_end;

   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      row_d   = row_q;
      col_d   = col_q;
      rem_d   = rem_q;
      wait_d  = wait_q;
      cross_d = cross_q;
      hold_d  = 1'b0;
      accept  = (state_q == S_IDLE) && !hold_q && i_init_done && i_write_start &&
                (i_wr_burst_len != '0);
      trp_end = ((state_q == S_PRE) && (T_RP == 0)) ||
                ((state_q == S_TRP) && (wait_q == '0));

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_ACT;
               {bank_d, row_d, col_d} = i_wr_addr;
               rem_d   = i_wr_burst_len;
               cross_d = 1'b0;
            end
         end
         S_ACT: begin
            if (T_RCD == 0) begin
               state_d = S_WRITE;
            end else begin
               state_d = S_TRCD;
               wait_d  = WAIT_W'(T_RCD - 1);
            end
         end
         S_TRCD: begin
            if (wait_q == '0) state_d = S_WRITE;
            else              wait_d  = wait_q - 1'b1;
         end
         S_WRITE: begin
            rem_d = rem_q - 1'b1;
            col_d = col_q + 1'b1;
            if (rem_q == LEN_W'(1)) begin
               state_d = S_BSTOP;
            end
`ifdef SDRAM_WR_ROW_CROSS_EN
            // Last column of the row with beats still owed: close the row and reopen the next one.
            else if (&col_q) begin
               state_d = S_BSTOP;
               cross_d = 1'b1;
            end
`endif
         end
         S_BSTOP: begin
            if (T_WR == 0) begin
               state_d = S_PRE;
            end else begin
               state_d = S_TWR;
               wait_d  = WAIT_W'(T_WR - 1);
            end
         end
         S_TWR: begin
            if (wait_q == '0) state_d = S_PRE;
            else              wait_d  = wait_q - 1'b1;
         end
         S_PRE: begin
            if (T_RP != 0) begin
               state_d = S_TRP;
               wait_d  = WAIT_W'(T_RP - 1);
            end
         end
         S_TRP: begin
            if (wait_q != '0) wait_d = wait_q - 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Row increment carries into the bank so the address space is walked linearly.
      if (trp_end) begin
         if (cross_q) begin
            state_d          = S_ACT;
            {bank_d, row_d}  = {bank_q, row_q} + 1'b1;
            cross_d          = 1'b0;
         end else begin
            state_d = S_DONE;
         end
      end

      // Outputs are decoded from the next state so they appear registered with the state.
      cmd_d  = CMD_NOP;
      ba_d   = '0;
      addr_d = '0;
      oe_d   = 1'b0;
      ack_d  = 1'b0;
      done_d = 1'b0;
      busy_d = (state_d != S_IDLE);
      case (state_d)
         S_ACT: begin
            cmd_d  = CMD_ACT;
            ba_d   = bank_d;
            addr_d = row_d;
         end
         S_WRITE: begin
            cmd_d  = (state_q == S_WRITE) ? CMD_NOP : CMD_WRITE;
            ba_d   = bank_d;
            addr_d = ROW_W'(col_d);
            oe_d   = 1'b1;
            ack_d  = 1'b1;
         end
         S_BSTOP: cmd_d = CMD_BSTOP;
         S_PRE: begin
            cmd_d  = CMD_PRE;
            addr_d = ADDR_A10;
         end
         S_DONE:  done_d = 1'b1;
         default: cmd_d  = CMD_NOP;
      endcase
   end

   always_ff @(posedge i_sysclk) begin
      if (i_sysrst) begin
         state_q <= S_IDLE;
         bank_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         rem_q   <= '0;
         wait_q  <= '0;
         cross_q <= 1'b0;
         hold_q  <= 1'b1;
         cmd_q   <= CMD_NOP;
         ba_q    <= '0;
         addr_q  <= '0;
         oe_q    <= 1'b0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bank_q  <= bank_d;
         row_q   <= row_d;
         col_q   <= col_d;
         rem_q   <= rem_d;
         wait_q  <= wait_d;
         cross_q <= cross_d;
         hold_q  <= hold_d;
         cmd_q   <= cmd_d;
         ba_q    <= ba_d;
         addr_q  <= addr_d;
         oe_q    <= oe_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign o_wr_cmd   = cmd_q;
   assign o_wr_ba    = ba_q;
   assign o_wr_addr  = addr_q;
   assign o_wr_dq_oe = oe_q;
   assign o_wr_ack   = ack_q;
   assign o_wr_done  = done_q;
   assign o_busy     = busy_q;
   assign o_wr_data  = oe_q ? i_wr_data : '0;
endmodule

// File: tb/tb_sdram_write_burst_ctrl.sv
// Scoreboard bench: each request expands into an expected command list, beat data and done pulse;
// a negedge monitor pops and checks them whenever the controller issues a command, an ack or done.
`timescale 1ns/1ps
module tb_sdram_write_burst_ctrl;
   localparam int DQ_W  = 16;
   localparam int ROW_W = 13;
   localparam int COL_W = 9;
   localparam int BA_W  = 2;
   localparam int LEN_W = 10;
   localparam int T_RCD = 2;
   localparam int T_WR  = 2;
   localparam int T_RP  = 2;
   localparam int AW    = BA_W + ROW_W + COL_W;
   localparam logic [3:0] NOP = 4'b0111;
   localparam logic [3:0] ACT = 4'b0011;
   localparam logic [3:0] WR  = 4'b0100;
   localparam logic [3:0] BST = 4'b0110;
   localparam logic [3:0] PRE = 4'b0010;

   logic              clk = 1'b0;
   logic              rst;
   logic              init_done;
   logic              start;
   logic [AW-1:0]     wr_addr;
   logic [LEN_W-1:0]  wr_len;
   logic [DQ_W-1:0]   wr_data_in;
   logic [3:0]        o_wr_cmd;
   logic [BA_W-1:0]   o_wr_ba;
   logic [ROW_W-1:0]  o_wr_addr;
   logic [DQ_W-1:0]   o_wr_data;
   logic              o_wr_dq_oe;
   logic              o_wr_ack;
   logic              o_wr_done;
   logic              o_busy;

   always #5 clk = ~clk;

   sdram_write_burst_ctrl #(
      .DQ_W(DQ_W), .ROW_W(ROW_W), .COL_W(COL_W), .BA_W(BA_W), .LEN_W(LEN_W),
      .T_RCD(T_RCD), .T_WR(T_WR), .T_RP(T_RP)
   ) dut (
      .i_sysclk(clk), .i_sysrst(rst), .i_init_done(init_done), .i_write_start(start),
      .i_wr_addr(wr_addr), .i_wr_burst_len(wr_len), .i_wr_data(wr_data_in),
      .o_wr_cmd(o_wr_cmd), .o_wr_ba(o_wr_ba), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
      .o_wr_dq_oe(o_wr_dq_oe), .o_wr_ack(o_wr_ack), .o_wr_done(o_wr_done), .o_busy(o_busy)
   );

   // mode: 0 = command only, 1 = check bank and address, 2 = check A10 only
   typedef struct {
      logic [3:0]       cmd;
      logic [BA_W-1:0]  ba;
      logic [ROW_W-1:0] addr;
      int               gap;
      int               mode;
   } exp_cmd_t;

   exp_cmd_t         cmd_q[$];
   logic [DQ_W-1:0]  beat_q[$];
   int               done_q[$];
   int               n_tests = 0;
   int               n_fail  = 0;
   int               data_ctr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Upstream source: presents a running counter, advancing after every consumed beat.
   initial begin
      logic ack_seen;
      wr_data_in = '0;
      forever begin
         @(negedge clk);
         ack_seen = o_wr_ack;
         @(posedge clk);
         #1;
         if (ack_seen) begin
            data_ctr++;
            wr_data_in = DQ_W'(data_ctr);
         end
      end
   end

   // Reference model: splits a request into row segments and lists the commands each needs.
   task automatic push_req(input int ba, input int row, input int col, input int len);
      int c, rem, n, k;
      bit first;
      logic [BA_W+ROW_W-1:0] br;
      exp_cmd_t e;
      c = col; rem = len; k = 0; first = 1'b1;
      br = {BA_W'(ba), ROW_W'(row)};
      while (rem > 0) begin
`ifdef SDRAM_WR_ROW_CROSS_EN
         n = (((1 << COL_W) - c) < rem) ? ((1 << COL_W) - c) : rem;
`else
         n = rem;
`endif
         e.cmd = ACT; e.ba = br[BA_W+ROW_W-1:ROW_W]; e.addr = br[ROW_W-1:0];
         e.gap = first ? -1 : T_RP + 1; e.mode = 1;
         cmd_q.push_back(e);
         e.cmd = WR; e.addr = ROW_W'(c); e.gap = T_RCD + 1; e.mode = 1;
         cmd_q.push_back(e);
         for (int i = 0; i < n; i++) begin
            beat_q.push_back(DQ_W'(data_ctr + k));
            k++;
         end
         e.cmd = BST; e.ba = '0; e.addr = '0; e.gap = n; e.mode = 0;
         cmd_q.push_back(e);
         e.cmd = PRE; e.gap = T_WR + 1; e.mode = 2;
         cmd_q.push_back(e);
         rem   = rem - n;
         c     = 0;
         br    = br + 1'b1;
         first = 1'b0;
      end
      done_q.push_back(T_RP + 1);
   endtask

   // Monitor
   initial begin
      int cyc, last_cmd, last_pre;
      exp_cmd_t e;
      logic [DQ_W-1:0] d;
      cyc = 0; last_cmd = 0; last_pre = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            if (o_wr_ack) begin
               chk("beat_oe", {31'd0, o_wr_dq_oe}, 32'd1);
               if (beat_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
               else begin
                  d = beat_q.pop_front();
                  chk("beat_data", {16'd0, o_wr_data}, {16'd0, d});
               end
            end else begin
               chk("idle_oe", {31'd0, o_wr_dq_oe}, 32'd0);
               chk("idle_data", {16'd0, o_wr_data}, 32'd0);
            end
            if (o_wr_cmd != NOP) begin
               if (cmd_q.size() == 0) chk("unexpected_cmd", {28'd0, o_wr_cmd}, {28'd0, NOP});
               else begin
                  e = cmd_q.pop_front();
                  chk("cmd", {28'd0, o_wr_cmd}, {28'd0, e.cmd});
                  if (e.gap >= 0) chk("cmd_gap", cyc - last_cmd, e.gap);
                  if (e.mode == 1) begin
                     chk("cmd_ba", {30'd0, o_wr_ba}, {30'd0, e.ba});
                     chk("cmd_addr", {19'd0, o_wr_addr}, {19'd0, e.addr});
                  end else if (e.mode == 2) begin
                     chk("pre_a10", {31'd0, o_wr_addr[10]}, 32'd1);
                  end
               end
               last_cmd = cyc;
               if (o_wr_cmd == PRE) last_pre = cyc;
            end
            if (o_wr_done) begin
               if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
               else chk("done_gap", cyc - last_pre, done_q.pop_front());
               chk("done_busy", {31'd0, o_busy}, 32'd1);
            end
         end
      end
   end

   task automatic drive_req(input int ba, input int row, input int col, input int len);
      push_req(ba, row, col, len);
      wr_addr = {BA_W'(ba), ROW_W'(row), COL_W'(col)};
      wr_len  = LEN_W'(len);
      start   = 1'b1;
   endtask

   task automatic scramble_inputs(input bit drop_init);
      start   = 1'b0;
      wr_addr = AW'($urandom);
      wr_len  = LEN_W'($urandom);
      if (drop_init) init_done = 1'b0;
   endtask

   task automatic issue(input int ba, input int row, input int col, input int len, input bit drop_init);
      @(negedge clk);
      #2;
      drive_req(ba, row, col, len);
      @(posedge clk);
      #1;
      chk("accept_act", {28'd0, o_wr_cmd}, {28'd0, ACT});
      chk("accept_busy", {31'd0, o_busy}, 32'd1);
      scramble_inputs(drop_init);
   endtask

   task automatic finish_req();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!o_wr_done && t < 4000);
      chk("done_seen", {31'd0, o_wr_done}, 32'd1);
      @(posedge clk);
      #1;
      chk("post_done_busy", {31'd0, o_busy}, 32'd0);
      chk("done_one_cycle", {31'd0, o_wr_done}, 32'd0);
      init_done = 1'b1;
   endtask

   initial begin
      int acks, t, col;
      rst = 1'b1; init_done = 1'b1; start = 1'b0; wr_addr = '0; wr_len = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd", {28'd0, o_wr_cmd}, {28'd0, NOP});
      chk("rst_ba", {30'd0, o_wr_ba}, 32'd0);
      chk("rst_addr", {19'd0, o_wr_addr}, 32'd0);
      chk("rst_oe", {31'd0, o_wr_dq_oe}, 32'd0);
      chk("rst_ack", {31'd0, o_wr_ack}, 32'd0);
      chk("rst_done", {31'd0, o_wr_done}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      issue(0, 0, 0, 10, 1'b0);   finish_req();
      issue(2, 5, 7, 1, 1'b0);    finish_req();
      issue(1, 100, 510, 4, 1'b0); finish_req();
      issue(3, 8191, 510, 4, 1'b0); finish_req();
      issue(0, 3, 500, 30, 1'b1); finish_req();

      // Zero length and missing init must both leave the controller idle.
      @(negedge clk);
      #2;
      wr_addr = AW'($urandom); wr_len = '0; start = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         chk("len0_busy", {31'd0, o_busy}, 32'd0);
         chk("len0_cmd", {28'd0, o_wr_cmd}, {28'd0, NOP});
      end
      init_done = 1'b0; wr_len = LEN_W'(5);
      repeat (20) begin
         @(posedge clk); #1;
         chk("noinit_busy", {31'd0, o_busy}, 32'd0);
         chk("noinit_cmd", {28'd0, o_wr_cmd}, {28'd0, NOP});
      end
      start = 1'b0; init_done = 1'b1;

      // Reset in the middle of a burst, then check the post-reset accept delay.
      issue(1, 20, 30, 12, 1'b0);
      acks = 0; t = 0;
      while (acks < 5 && t < 200) begin
         @(negedge clk); #2;
         if (o_wr_ack) acks++;
         t++;
      end
      chk("rst_reach_ack5", acks, 5);
      rst = 1'b1;
      cmd_q.delete(); beat_q.delete(); done_q.delete();
      @(posedge clk); #1;
      chk("midrst_cmd", {28'd0, o_wr_cmd}, {28'd0, NOP});
      chk("midrst_oe", {31'd0, o_wr_dq_oe}, 32'd0);
      chk("midrst_ack", {31'd0, o_wr_ack}, 32'd0);
      chk("midrst_busy", {31'd0, o_busy}, 32'd0);
      chk("midrst_done", {31'd0, o_wr_done}, 32'd0);
      rst = 1'b0;
      @(negedge clk); #2;
      drive_req(2, 77, 100, 6);
      @(posedge clk); #1;
      chk("rel_first_edge_cmd", {28'd0, o_wr_cmd}, {28'd0, NOP});
      chk("rel_first_edge_busy", {31'd0, o_busy}, 32'd0);
      @(posedge clk); #1;
      chk("rel_second_edge_cmd", {28'd0, o_wr_cmd}, {28'd0, ACT});
      chk("rel_second_edge_busy", {31'd0, o_busy}, 32'd1);
      scramble_inputs(1'b0);
      finish_req();

      for (int i = 0; i < 16; i++) begin
         col = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 511)) :
                                             511 - int'($urandom_range(0, 8));
         issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 8191)), col,
               int'($urandom_range(1, 40)), bit'($urandom_range(0, 1)));
         finish_req();
      end

      repeat (4) @(posedge clk);
      #1;
      chk("left_cmds", cmd_q.size(), 0);
      chk("left_beats", beat_q.size(), 0);
      chk("left_done", done_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
